// File: rtl/ph_arb_if.sv
// ph_arb_if: groups the ph_arb output stream and the fx configuration bus.
//   Output stream : arb_data, arb_ch, arb_vld (to consumer), arb_rdy (from consumer)
//   fx write      : fx_waddr, fx_wr, fx_data
//   fx read       : fx_raddr, fx_rd, fx_q (registered read data from the slave)
// Modports:
//   slave  - the arbiter side (drives the stream and fx_q)
//   master - the consumer / bus-master side
interface ph_arb_if #(
   parameter int unsigned DW = 16
);
   logic [DW-1:0] arb_data;
   logic [2:0]    arb_ch;
   logic          arb_vld;
   logic          arb_rdy;
   logic [21:0]   fx_waddr;
   logic          fx_wr;
   logic [7:0]    fx_data;
   logic          fx_rd;
   logic [21:0]   fx_raddr;
   logic [7:0]    fx_q;

   modport slave (
      output arb_data, arb_ch, arb_vld, fx_q,
      input  arb_rdy, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr
   );

   modport master (
      input  arb_data, arb_ch, arb_vld, fx_q,
      output arb_rdy, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr
   );
endinterface

// File: rtl/ph_arb.sv
// ph_arb: round-robin arbiter merging eight per-channel parameter streams into one
// channel-tagged output stream. Each channel owns a one-entry holding register with a
// pending flag; a second word arriving before the first is granted overwrites it and
// sets a sticky overflow bit.
// Ports:
//   i_clk_sys  - system clock, rising edge
//   i_rst_n    - asynchronous active-low reset
//   i_dev_id   - fx bus device id, matched against address bits [21:16]
//   i_ph_ring  - channel i data on bits [DW*i +: DW]
//   i_ph_vld   - per-channel one-cycle valid pulse
//   bus        - ph_arb_if slave: output stream + fx register bus
// fx register map (offset = address[15:0]):
//   0x0000 mask (RW), 0x0001 ovf (R, W1C), 0x0002 pend (RO),
//   0x0003 cnt[7:0] (RO), 0x0004 cnt[15:8] (RO); other offsets read 0.
module ph_arb #(
   parameter int unsigned DW  = 16,
   parameter int unsigned NCH = 8
) (
   input  logic              i_clk_sys,
   input  logic              i_rst_n,
   input  logic [5:0]        i_dev_id,
   input  logic [DW*NCH-1:0] i_ph_ring,
   input  logic [NCH-1:0]    i_ph_vld,
   ph_arb_if.slave           bus
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e         r_state;
   logic [DW-1:0]  r_hold [NCH];
   logic [NCH-1:0] r_pend;
   logic [NCH-1:0] r_ovf;
   logic [NCH-1:0] r_mask;
   logic [2:0]     r_ptr;
   logic [15:0]    r_cnt;
   logic [DW-1:0]  r_arb_data;
   logic [2:0]     r_arb_ch;
   logic           r_arb_vld;
   logic [7:0]     r_fx_q;

   logic [NCH-1:0] w_cap;
   logic [NCH-1:0] w_grant;
   logic [NCH-1:0] w_mask_clr;
   logic [NCH-1:0] w_ovf_set;
   logic [NCH-1:0] w_pend_d;
   logic [NCH-1:0] w_ovf_d;
   logic [2:0]     w_sel;
   logic [2:0]     w_idx;
   logic           w_found;
   logic           w_do_grant;
   logic           w_wsel;
   logic           w_wr_mask;
   logic           w_wr_ovf;
   logic           w_rsel;
   logic [7:0]     w_rd_data;

   // Round-robin search: first pending channel at or above r_ptr, wrapping 7->0.
   always_comb begin
      w_sel   = 3'd0;
      w_idx   = 3'd0;
      w_found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         w_idx = r_ptr + 3'(k);
         if (!w_found && r_pend[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_cap      = i_ph_vld & r_mask;
      w_do_grant = (r_state == StIdle) && (r_pend != '0);
      w_grant    = w_do_grant ? (NCH'(1) << w_sel) : '0;

      w_wsel    = bus.fx_wr && (bus.fx_waddr[21:16] == i_dev_id);
      w_wr_mask = w_wsel && (bus.fx_waddr[15:0] == 16'h0000);
      w_wr_ovf  = w_wsel && (bus.fx_waddr[15:0] == 16'h0001);

      w_mask_clr = w_wr_mask ? ~bus.fx_data : '0;
      // A capture on the channel being granted refills pend without counting as overflow.
      w_ovf_set  = w_cap & r_pend & ~w_grant;
      w_pend_d   = ((r_pend & ~w_grant) | w_cap) & ~w_mask_clr;
      // Set beats write-1-to-clear on the same edge.
      w_ovf_d    = (r_ovf & ~(w_wr_ovf ? bus.fx_data : '0)) | w_ovf_set;

      w_rsel = bus.fx_raddr[21:16] == i_dev_id;
      unique case (bus.fx_raddr[15:0])
         16'h0000: w_rd_data = r_mask;
         16'h0001: w_rd_data = r_ovf;
         16'h0002: w_rd_data = r_pend;
         16'h0003: w_rd_data = r_cnt[7:0];
         16'h0004: w_rd_data = r_cnt[15:8];
         default:  w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_pend     <= '0;
         r_ovf      <= '0;
         r_mask     <= '1;
         r_ptr      <= 3'd0;
         r_cnt      <= 16'd0;
         r_arb_data <= '0;
         r_arb_ch   <= 3'd0;
         r_arb_vld  <= 1'b0;
         r_fx_q     <= 8'h00;
         for (int i = 0; i < NCH; i++) begin
            r_hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_cap[i]) begin
               r_hold[i] <= i_ph_ring[DW*i +: DW];
            end
         end
         r_pend <= w_pend_d;
         r_ovf  <= w_ovf_d;
         if (w_wr_mask) begin
            r_mask <= bus.fx_data;
         end
         if (bus.fx_rd) begin
            r_fx_q <= w_rsel ? w_rd_data : 8'h00;
         end

         unique case (r_state)
            StIdle: begin
               if (w_do_grant) begin
                  r_arb_data <= r_hold[w_sel];
                  r_arb_ch   <= w_sel;
                  r_arb_vld  <= 1'b1;
                  r_state    <= StSend;
               end
            end
            StSend: begin
               if (r_arb_vld && bus.arb_rdy) begin
                  r_arb_vld <= 1'b0;
                  r_ptr     <= r_arb_ch + 3'd1;
                  r_cnt     <= r_cnt + 16'd1;
                  r_state   <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.arb_data = r_arb_data;
   assign bus.arb_ch   = r_arb_ch;
   assign bus.arb_vld  = r_arb_vld;
   assign bus.fx_q     = r_fx_q;

endmodule
